pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined successor to the combinational B-bit adder. Splits a B-bit add/subtract into S equal slices and registers the carry between slices, so each stage has a W-bit ripple path. Accepts one operand pair per cycle and returns sum, carry-out and signed overflow S cycles later. Used on wide datapaths where a single B-bit ripple chain misses timing.

## Interface
- B, 12, operand/result width in bits; must be a multiple of S.
- S, 3, pipeline stage count = slice count; 1 ≤ S ≤ B.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low; one clock, reset is synchronous and active-low.
- en  in  1  global advance; 0 freezes every pipeline register.
- valid_in  in  1  a/b/cin/sub are valid this cycle.
- a  in  B  operand A, two's complement or unsigned.
- b  in  B  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: s=a+b+cin; 1: s=a-b (a+~b+1), cin ignored.
- s  out  B  result, registered.
- cout  out  1  carry out of bit B-1; for sub, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow of the B-bit operation.
- valid_out  out  1  s/cout/ovf hold a result this cycle.

## Operation
- W = B/S. Stage k (0..S-1) adds slice k of a and b' (b' = sub ? ~b : b) plus the carry registered from stage k-1; stage 0 takes carry-in = sub ? 1 : cin.
- Input skew: slice k of a and b' is delayed k cycles before reaching stage k. Output de-skew: the sum slice from stage k is delayed S-1-k cycles so all slices of one result emerge together.
- Final stage also produces cout (carry out of the top slice) and ovf = (a[B-1] == b'[B-1]) && (s[B-1] != a[B-1]); a[B-1] and b'[B-1] travel with the top slice.
- valid travels in an S-deep shift register alongside data. Data registers load every en=1 cycle regardless of valid_in; s/cout/ovf are don't-care when valid_out=0, but must be deterministic (never X after reset).
- S=1 degenerates to a single registered B-bit adder, latency 1.
- Wrap-around: result is modulo 2^B; no saturation.

## Timing
- Reset (rst_n=0 at a rising edge): every pipeline register, including s, cout, ovf, valid_out, is cleared to 0 at that edge. Reset wins over en.
- Latency: a pair sampled with valid_in=1, en=1 at edge t appears with valid_out=1 after edge t+S-1, i.e. S register stages.
- Throughput: one result per cycle while en=1; results leave in input order.
- en=0: no register changes; valid_out and outputs hold; the input at that edge is not captured.
- Reset mid-stream: all in-flight results are discarded; valid_out=0 from the edge after reset until new inputs have propagated for S edges.
- Carry across slices is never combinational between stages; the longest combinational path is one W-bit slice plus the input XOR for sub.

## Structure
- Shared package/header adder_pkg: default B and S, the derived W, and the B % S == 0 legality check (elaboration-time error).
- One sub-module adder_slice #(W): combinational W-bit ripple adder with cin/cout, instantiated S times via generate.
- Skew/de-skew delay lines and the valid shift register live in pipelined_adder.

## Test plan (B=12, S=3)
- Basic: a=12, b=13, cin=0, sub=0 -> after 3 cycles s=25, cout=0, ovf=0, valid_out=1 for exactly one cycle.
- Full carry ripple: a=0xFFF, b=0, cin=1 -> s=0x000, cout=1, ovf=0; a=0x7FF, b=1, cin=0 -> s=0x800, cout=0, ovf=1.
- Subtract: a=54, b=54, sub=1 -> s=0, cout=1, ovf=0; a=0x800, b=1, sub=1 -> s=0x7FF, cout=1, ovf=1; a=0, b=1, sub=1 -> s=0xFFF, cout=0, ovf=0.
- Streaming: back-to-back pairs (232,-32), (-900,1000), (-232,-32) -> s=200, 100, 0xEF8 (-264) on three consecutive cycles, valid_out high for all three.
- Stall: same stream with en=0 for 2 cycles after the second input -> outputs and valid_out frozen during stall, all three results still correct and in order, total delay extended by 2.
- Reset: assert rst_n=0 for one edge with two results in flight -> s=0, cout=0, ovf=0, valid_out=0 immediately after that edge; no stale result emerges afterwards.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared geometry for the pipelined adder: default width, slice count and the
// legality rule that keeps every slice the same width.
package adder_pkg;

  localparam int unsigned B_DEFAULT = 12;
  localparam int unsigned S_DEFAULT = 3;
  localparam int unsigned W_DEFAULT = B_DEFAULT / S_DEFAULT;

  // A geometry is usable only if the width splits into 1..B equal slices.
  function automatic bit geometryLegal(input int unsigned b, input int unsigned s);
    return (s >= 1) && (s <= b) && ((b % s) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One W-bit combinational ripple-carry slice; the pipeline places one of these
// between each pair of carry registers.
module adder_slice
  import adder_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_carry;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    w_carry    = '0;
    o_sum      = '0;
    w_carry[0] = i_cin;
    for (int i = 0; i < W; i++) begin
      o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_carry[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined B-bit add/subtract split into S slices with a register on every
// inter-slice carry. Operand slices are skewed in, sum slices de-skewed out,
// so one result per cycle emerges S cycles after its operands.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned B = B_DEFAULT,
  parameter int unsigned S = S_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid_in,
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [B-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         valid_out
);

  localparam int unsigned W = B / S;

  if (!geometryLegal(B, S)) begin : gBadGeometry
    $error("pipelined_adder: B=%0d cannot be split into S=%0d equal slices", B, S);
  end

  logic [B-1:0] w_bEff;
  logic         w_cin0;
  logic [S-1:0] w_carryReg;
  logic         w_topA;
  logic         w_topB;
  logic         w_topSum;
  logic [S-1:0] r_valid;
  logic         r_ovf;

  // Subtraction is a + ~b + 1, so the inversion and the forced carry-in
  // happen before any slicing.
  assign w_bEff = sub ? ~b : b;
  assign w_cin0 = sub ? 1'b1 : cin;

  for (genvar k = 0; k < S; k++) begin : gStage
    logic [W-1:0] w_aStage;
    logic [W-1:0] w_bStage;
    logic [W-1:0] w_sum;
    logic         w_cinStage;
    logic         w_cout;
    logic         r_carry;
    logic [W-1:0] r_sumDly [0:S-1-k];

    if (k == 0) begin : gNoSkew
      assign w_aStage   = a[W-1:0];
      assign w_bStage   = w_bEff[W-1:0];
      assign w_cinStage = w_cin0;
    end else begin : gSkew
      logic [W-1:0] r_aDly [0:k-1];
      logic [W-1:0] r_bDly [0:k-1];

      // Hold operand slice k back k cycles so it meets the carry from below.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int d = 0; d < k; d++) begin
            r_aDly[d] <= '0;
            r_bDly[d] <= '0;
          end
        end else if (en) begin
          r_aDly[0] <= a[k*W +: W];
          r_bDly[0] <= w_bEff[k*W +: W];
          for (int d = 1; d < k; d++) begin
            r_aDly[d] <= r_aDly[d-1];
            r_bDly[d] <= r_bDly[d-1];
          end
        end
      end

      assign w_aStage   = r_aDly[k-1];
      assign w_bStage   = r_bDly[k-1];
      assign w_cinStage = w_carryReg[k-1];
    end

    adder_slice #(.W(W)) uSlice (
      .i_a   (w_aStage),
      .i_b   (w_bStage),
      .i_cin (w_cinStage),
      .o_sum (w_sum),
      .o_cout(w_cout)
    );

    // Register the slice carry for the next stage and push the sum slice
    // into a delay line long enough that all slices leave together.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_carry <= 1'b0;
        for (int d = 0; d <= int'(S) - 1 - k; d++) begin
          r_sumDly[d] <= '0;
        end
      end else if (en) begin
        r_carry     <= w_cout;
        r_sumDly[0] <= w_sum;
        for (int d = 1; d <= int'(S) - 1 - k; d++) begin
          r_sumDly[d] <= r_sumDly[d-1];
        end
      end
    end

    assign w_carryReg[k]  = r_carry;
    assign s[k*W +: W]    = r_sumDly[S-1-k];

    if (k == S - 1) begin : gTop
      assign w_topA   = w_aStage[W-1];
      assign w_topB   = w_bStage[W-1];
      assign w_topSum = w_sum[W-1];
    end
  end

  // Signed overflow is judged in the top stage from the sign bits that
  // travelled with the top slice, and registered alongside its carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (en) begin
      r_ovf <= (w_topA == w_topB) && (w_topSum != w_topA);
    end
  end

  // Valid marker shifts through S stages in lockstep with the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (en) begin
      r_valid[0] <= valid_in;
      for (int i = 1; i < int'(S); i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign cout      = w_carryReg[S-1];
  assign ovf       = r_ovf;
  assign valid_out = r_valid[S-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (B=12, S=3): table vectors with fixed answers,
// hand-timed stream/stall/reset sequences, and random traffic checked against
// an arithmetic reference model with a queue of pending results.
module tb_pipelined_adder;

  localparam int B = 12;
  localparam int S = 3;
  localparam int NVEC = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         valid_in;
  logic [B-1:0] a;
  logic [B-1:0] b;
  logic         cin;
  logic         sub;
  logic [B-1:0] s;
  logic         cout;
  logic         ovf;
  logic         valid_out;

  int total = 0;
  int bad   = 0;
  int enCount = 0;
  bit checkOn = 1'b0;

  typedef struct {
    logic [B-1:0] s;
    logic         cout;
    logic         ovf;
    int           due;
  } pend_t;

  typedef struct {
    logic [B-1:0] a;
    logic [B-1:0] b;
    logic         cin;
    logic         sub;
    logic [B-1:0] expS;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  pend_t q[$];
  pend_t pNew;
  vec_t  vecs[NVEC];

  pipelined_adder #(.B(B), .S(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .valid_in (valid_in),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: plain integer add/subtract plus signed range test.
  function automatic pend_t refModel(input logic [B-1:0] ia, input logic [B-1:0] ib,
                                     input logic icin, input logic isub);
    pend_t r;
    int ua, ub, sa, sb, full, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = ia[B-1] ? ua - (1 << B) : ua;
    sb = ib[B-1] ? ub - (1 << B) : ub;
    if (isub) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
      sr     = sa - sb;
      if (full < 0) full = full + (1 << B);
    end else begin
      full   = ua + ub + int'(icin);
      r.cout = (full >= (1 << B));
      sr     = sa + sb + int'(icin);
      full   = full % (1 << B);
    end
    r.s   = B'(full);
    r.ovf = (sr > (1 << (B - 1)) - 1) || (sr < -(1 << (B - 1)));
    r.due = 0;
    return r;
  endfunction

  // Track accepted operands: each is due once S enabled edges have passed.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (en) begin
      enCount = enCount + 1;
      if (valid_in) begin
        pNew     = refModel(a, b, cin, sub);
        pNew.due = enCount + S - 1;
        q.push_back(pNew);
      end
      while (q.size() > 0 && q[0].due < enCount) void'(q.pop_front());
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      total = total + 1;
      if (q.size() > 0 && q[0].due == enCount) begin
        if (valid_out !== 1'b1 || s !== q[0].s || cout !== q[0].cout || ovf !== q[0].ovf) begin
          bad = bad + 1;
          $display("[TB] FAIL model: got valid=%b s=%h cout=%b ovf=%b, want valid=1 s=%h cout=%b ovf=%b",
                   valid_out, s, cout, ovf, q[0].s, q[0].cout, q[0].ovf);
        end
      end else if (valid_out !== 1'b0 || $isunknown({s, cout, ovf})) begin
        bad = bad + 1;
        $display("[TB] FAIL model_idle: got valid=%b s=%h cout=%b ovf=%b, want valid=0 and no X",
                 valid_out, s, cout, ovf);
      end
    end
  end

  task automatic applyStimulus(input logic [B-1:0] ia, input logic [B-1:0] ib,
                               input logic icin, input logic isub, input logic ivalid,
                               input logic ien, input logic irst);
    @(negedge clk);
    #1;
    a        = ia;
    b        = ib;
    cin      = icin;
    sub      = isub;
    valid_in = ivalid;
    en       = ien;
    rst_n    = irst;
  endtask

  task automatic idle(input logic ien, input logic irst);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, ien, irst);
  endtask

  task automatic checkOutput(input string name, input logic [B-1:0] expS, input logic expCout,
                             input logic expOvf, input logic expValid, input bit checkVals);
    total = total + 1;
    if (valid_out !== expValid ||
        (checkVals && (s !== expS || cout !== expCout || ovf !== expOvf))) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got valid=%b s=%h cout=%b ovf=%b, want valid=%b s=%h cout=%b ovf=%b",
               name, valid_out, s, cout, ovf, expValid, expS, expCout, expOvf);
    end
  endtask

  task automatic waitForValid(input string name, input int expWait);
    int n = 0;
    while (valid_out !== 1'b1 && n < 12) begin
      @(negedge clk);
      #1;
      n++;
    end
    total = total + 1;
    if (n != expWait) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got wait=%0d cycles, want %0d", name, n, expWait);
    end
  endtask

  initial begin
    vecs[0] = '{12'd12,   12'd13,  1'b0, 1'b0, 12'd25,  1'b0, 1'b0};
    vecs[1] = '{12'hFFF,  12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[2] = '{12'h7FF,  12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
    vecs[3] = '{12'd54,   12'd54,  1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[4] = '{12'h800,  12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
    vecs[5] = '{12'h000,  12'h001, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0};
    vecs[6] = '{12'd232,  12'hFE0, 1'b0, 1'b0, 12'd200, 1'b1, 1'b0};
    vecs[7] = '{12'hC7C,  12'd1000,1'b0, 1'b0, 12'd100, 1'b1, 1'b0};
    vecs[8] = '{12'hF18,  12'hFE0, 1'b0, 1'b0, 12'hEF8, 1'b1, 1'b0};
    vecs[9] = '{12'd5,    12'd3,   1'b1, 1'b1, 12'd2,   1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b1; valid_in = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOn = 1'b1;
    checkOutput("reset_state", '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b1);

    // Single vectors: latency S, one-cycle valid pulse.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1'b1);
      waitForValid($sformatf("latency_vec%0d", i), S - 1);
      checkOutput($sformatf("vec%0d", i), vecs[i].expS, vecs[i].expCout, vecs[i].expOvf, 1'b1, 1'b1);
      idle(1'b1, 1'b1);
      checkOutput($sformatf("pulse_vec%0d", i), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Back-to-back stream.
    for (int i = 6; i < 9; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stream0", 12'd200, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stream1", 12'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stream2", 12'hEF8, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stream_end", '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall two cycles after the second input, then hold while a result is out.
    applyStimulus(vecs[6].a, vecs[6].b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(vecs[7].a, vecs[7].b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(vecs[8].a, vecs[8].b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(vecs[8].a, vecs[8].b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("stall_a", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(vecs[8].a, vecs[8].b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("stall_b", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    checkOutput("stall_out0", 12'd200, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("stall_out1", 12'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("hold1", 12'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("hold2", 12'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stall_out2", 12'hEF8, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("stall_end", '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with two results in flight.
    applyStimulus(vecs[6].a, vecs[6].b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(vecs[7].a, vecs[7].b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    checkOutput("reset_flush", '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, 1'b1);
      checkOutput($sformatf("no_stale%0d", i), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(B'($urandom), B'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 9),
                    ($urandom_range(0, 99) != 0));
    end
    repeat (2 * S + 2) idle(1'b1, 1'b1);

    @(negedge clk);
    #1;
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
